// File: rtl/mul_stage_arbiter_if.sv
// Handshake bundle between the neuron-update requesters, the arbiter and the
// shared multiply stage. The master side is the requester lanes plus the
// multiplier; the slave side is the arbiter sitting between them.
interface mul_stage_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;

    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_data;

    logic                    mul_srcReady;
    logic                    mul_readyForInput;
    logic [DATA_W-1:0]       mul_in_A;
    logic [DATA_W-1:0]       mul_in_B;
    logic                    mul_outputReadyEn;
    logic                    mul_destReady;
    logic [DATA_W-1:0]       mul_result;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output mul_readyForInput, mul_outputReadyEn, mul_result,
        input  req_ready, rsp_valid, rsp_data,
        input  mul_srcReady, mul_in_A, mul_in_B, mul_destReady
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  mul_readyForInput, mul_outputReadyEn, mul_result,
        output req_ready, rsp_valid, rsp_data,
        output mul_srcReady, mul_in_A, mul_in_B, mul_destReady
    );
endinterface

// File: rtl/mul_stage_arbiter.sv
// Shares one multiply stage among N_REQ requesters. Issue slots are granted
// round-robin; the requester index of every accepted operation is queued in an
// in-order tag FIFO so each product can be routed back to its issuer.
module mul_stage_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    mul_stage_arbiter_if.slave              bus,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err_orphan
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W:0]    sum;
    logic              any_valid;
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              can_issue;
    logic              issue;
    logic              deliver;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [N_REQ-1:0]  ready_vec;
    logic [N_REQ-1:0]  rsp_vec;

    assign full  = (count == CNT_W'(MAX_INFLIGHT));
    assign empty = (count == '0);

    // Pick the first valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_valid && bus.req_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    // Steer the granted requester's operands to the multiplier (zero when idle)
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (any_valid && grant == IDX_W'(i)) begin
                op_a = bus.req_a[i*DATA_W +: DATA_W];
                op_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // A full FIFO blocks issue even if it pops this cycle, keeping rsp_ready
    // off the srcReady path; rst gating keeps the handshake quiet in reset.
    assign can_issue = any_valid && !full && rst;
    assign issue     = can_issue && bus.mul_readyForInput;
    assign head      = tag_mem[rd_ptr];
    assign deliver   = bus.mul_outputReadyEn && bus.mul_destReady;

    // One-hot accept for the granted requester and result valid for the head tag
    always_comb begin
        ready_vec = '0;
        rsp_vec   = '0;
        if (issue) begin
            ready_vec[grant] = 1'b1;
        end
        if (bus.mul_outputReadyEn && !empty) begin
            rsp_vec[head] = 1'b1;
        end
    end

    assign bus.req_ready     = ready_vec;
    assign bus.rsp_valid     = rsp_vec;
    assign bus.rsp_data      = bus.mul_result;
    assign bus.mul_srcReady  = can_issue;
    assign bus.mul_in_A      = op_a;
    assign bus.mul_in_B      = op_b;
    assign bus.mul_destReady = !empty && bus.rsp_ready[head];
    assign inflight          = count;

    // Round-robin pointer, FIFO pointers, occupancy and sticky orphan flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);
            end
            if (deliver) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (issue && !deliver) begin
                count <= count + CNT_W'(1);
            end else if (!issue && deliver) begin
                count <= count - CNT_W'(1);
            end
            if (bus.mul_outputReadyEn && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage; stale entries are harmless because the pointers are reset
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= grant;
        end
    end
endmodule

// File: tb/tb_mul_stage_arbiter.sv
// Self-checking bench for mul_stage_arbiter: a behavioural in-order multiplier
// with one cycle of latency, a scoreboard of expected {requester, product}
// pairs, a table of grant vectors and hand-written multi-cycle sequences.
module tb_mul_stage_arbiter;
    localparam int N_REQ        = 4;
    localparam int DATA_W       = 16;
    localparam int MAX_INFLIGHT = 4;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_src;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  inflight;
    logic        err_orphan;

    logic [15:0] op_a [4];
    logic [15:0] op_b [4];
    exp_t        exp_q [$];
    logic [15:0] mul_q [$];
    logic        mul_vld_r;
    logic [15:0] mul_data_r;
    logic        mul_en;
    logic        orphan_force;
    logic [1:0]  exp_ptr;
    int          n_vec   = 0;
    int          n_err   = 0;
    int          n_issue = 0;
    vec_t        tbl [6];

    mul_stage_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    mul_stage_arbiter #(
        .N_REQ(N_REQ),
        .DATA_W(DATA_W),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .inflight(inflight),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    assign bus.req_a             = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign bus.req_b             = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign bus.mul_outputReadyEn = (mul_vld_r && mul_en) || orphan_force;
    assign bus.mul_result        = mul_data_r;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic rfi, input logic [3:0] rdy);
        bus.req_valid         = valid;
        bus.mul_readyForInput = rfi;
        bus.rsp_ready         = rdy;
    endtask

    task automatic resetDut();
        rst          = 1'b0;
        mul_en       = 1'b0;
        orphan_force = 1'b0;
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int cyc = 0;
        while (inflight != 3'd0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(name, 32'(inflight), 0);
        checkOutput({name, "_sb"}, exp_q.size(), 0);
    endtask

    function automatic logic [1:0] modelGrant(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] c;
        for (int k = 0; k < 4; k++) begin
            c = 2'(int'(p) + k);
            if (v[c]) return c;
        end
        return 2'd0;
    endfunction

    // Behavioural multiplier plus scoreboard: checks each delivery and issue
    always @(posedge clk or negedge rst) begin
        logic [31:0] full_prod;
        logic [1:0]  g;
        exp_t        e;
        if (!rst) begin
            mul_q.delete();
            exp_q.delete();
            exp_ptr = 2'd0;
            mul_vld_r  <= 1'b0;
            mul_data_r <= 16'h0;
        end else begin
            if (bus.mul_outputReadyEn && bus.mul_destReady) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_unexpected_delivery", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.idx);
                    checkOutput("sb_rsp_data", 32'(bus.rsp_data), 32'(e.data));
                end
                if (mul_q.size() != 0) void'(mul_q.pop_front());
            end
            if (bus.mul_srcReady && bus.mul_readyForInput) begin
                g = modelGrant(bus.req_valid, exp_ptr);
                checkOutput("sb_req_ready", 32'(bus.req_ready), 32'(1) << g);
                full_prod = bus.mul_in_A * bus.mul_in_B;
                mul_q.push_back(full_prod[15:0]);
                full_prod = op_a[g] * op_b[g];
                e.idx  = g;
                e.data = full_prod[15:0];
                exp_q.push_back(e);
                exp_ptr = g + 2'd1;
                n_issue++;
            end
            mul_vld_r  <= (mul_q.size() != 0);
            mul_data_r <= (mul_q.size() != 0) ? mul_q[0] : 16'h0;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic [31:0] p;
        op_a = '{16'h57B7, 16'h1234, 16'hA5A5, 16'h0F0F};
        op_b = '{16'hD7B7, 16'h0003, 16'h5A5A, 16'h00FF};
        tbl[0] = '{4'b0000, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{4'b0001, 16'h57B7, 16'hD7B7, 1'b1};
        tbl[2] = '{4'b0110, 16'h1234, 16'h0003, 1'b1};
        tbl[3] = '{4'b1000, 16'h0F0F, 16'h00FF, 1'b1};
        tbl[4] = '{4'b1100, 16'hA5A5, 16'h5A5A, 1'b1};
        tbl[5] = '{4'b1010, 16'h1234, 16'h0003, 1'b1};

        rst          = 1'b1;
        mul_en       = 1'b0;
        orphan_force = 1'b0;
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        #2 rst = 1'b0;
        applyStimulus(4'b1111, 1'b1, 4'b1111);
        #3;
        $display("[TB] reset state");
        checkOutput("rst_inflight", 32'(inflight), 0);
        checkOutput("rst_err", 32'(err_orphan), 0);
        checkOutput("rst_src", 32'(bus.mul_srcReady), 0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("rst_dest", 32'(bus.mul_destReady), 0);
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] grant table, rr_ptr at 0, multiplier not ready");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i].valid, 1'b0, 4'b0000);
            #1;
            checkOutput($sformatf("tbl%0d_src", i), 32'(bus.mul_srcReady), 32'(tbl[i].exp_src));
            checkOutput($sformatf("tbl%0d_in_a", i), 32'(bus.mul_in_A), 32'(tbl[i].exp_a));
            checkOutput($sformatf("tbl%0d_in_b", i), 32'(bus.mul_in_B), 32'(tbl[i].exp_b));
            checkOutput($sformatf("tbl%0d_req_ready", i), 32'(bus.req_ready), 0);
        end

        $display("[TB] single request");
        resetDut();
        applyStimulus(4'b0001, 1'b1, 4'b1111);
        mul_en = 1'b1;
        #1;
        checkOutput("t1_req_ready", 32'(bus.req_ready), 1);
        checkOutput("t1_in_a", 32'(bus.mul_in_A), 'h57B7);
        checkOutput("t1_in_b", 32'(bus.mul_in_B), 'hD7B7);
        @(posedge clk);
        #1 bus.req_valid = 4'b0000;
        @(negedge clk);
        p = 32'h57B7 * 32'hD7B7;
        checkOutput("t1_inflight", 32'(inflight), 1);
        checkOutput("t1_rsp_valid", 32'(bus.rsp_valid), 1);
        checkOutput("t1_rsp_data", 32'(bus.rsp_data), 32'(p[15:0]));
        @(negedge clk);
        checkOutput("t1_inflight_after", 32'(inflight), 0);

        $display("[TB] round-robin fairness");
        resetDut();
        applyStimulus(4'b1111, 1'b1, 4'b1111);
        mul_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("t2_grant%0d", k), 32'(bus.req_ready), 32'(1) << (k % 4));
            @(negedge clk);
        end
        applyStimulus(4'b0000, 1'b0, 4'b1111);
        waitDrain("t2_drain");

        $display("[TB] full stall");
        resetDut();
        applyStimulus(4'b1111, 1'b1, 4'b0000);
        mul_en = 1'b1;
        base = n_issue;
        repeat (6) @(negedge clk);
        checkOutput("t3_issues", n_issue - base, 4);
        checkOutput("t3_src_full", 32'(bus.mul_srcReady), 0);
        checkOutput("t3_inflight", 32'(inflight), 4);
        checkOutput("t3_dest_stalled", 32'(bus.mul_destReady), 0);
        checkOutput("t3_rsp_valid_head", 32'(bus.rsp_valid), 1);
        bus.rsp_ready = 4'b1111;
        #1;
        checkOutput("t3_src_still_blocked", 32'(bus.mul_srcReady), 0);
        checkOutput("t3_dest_resume", 32'(bus.mul_destReady), 1);
        @(negedge clk);
        checkOutput("t3_src_after_pop", 32'(bus.mul_srcReady), 1);
        checkOutput("t3_inflight_after_pop", 32'(inflight), 3);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 4'b1111);
        waitDrain("t3_drain");

        $display("[TB] routing order");
        resetDut();
        applyStimulus(4'b0100, 1'b1, 4'b1011);
        @(negedge clk);
        applyStimulus(4'b0001, 1'b1, 4'b1011);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 4'b1011);
        mul_en = 1'b1;
        #1;
        checkOutput("t4_first_rsp", 32'(bus.rsp_valid), 'h4);
        checkOutput("t4_dest_held", 32'(bus.mul_destReady), 0);
        repeat (2) @(negedge clk);
        checkOutput("t4_dest_still_held", 32'(bus.mul_destReady), 0);
        checkOutput("t4_inflight", 32'(inflight), 2);
        bus.rsp_ready = 4'b1111;
        #1;
        checkOutput("t4_dest_release", 32'(bus.mul_destReady), 1);
        @(negedge clk);
        checkOutput("t4_second_rsp", 32'(bus.rsp_valid), 'h1);
        waitDrain("t4_drain");

        $display("[TB] orphan result");
        resetDut();
        applyStimulus(4'b0000, 1'b0, 4'b1111);
        orphan_force = 1'b1;
        #1;
        checkOutput("t5_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("t5_dest", 32'(bus.mul_destReady), 0);
        checkOutput("t5_err_before", 32'(err_orphan), 0);
        @(negedge clk);
        checkOutput("t5_err_set", 32'(err_orphan), 1);
        orphan_force = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_err_sticky", 32'(err_orphan), 1);
        checkOutput("t5_inflight", 32'(inflight), 0);

        $display("[TB] reset mid-flight");
        resetDut();
        applyStimulus(4'b0111, 1'b1, 4'b0000);
        repeat (3) @(negedge clk);
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        #1;
        checkOutput("t6_inflight_pre", 32'(inflight), 3);
        @(posedge clk);
        #3 rst = 1'b0;
        bus.mul_readyForInput = 1'b1;
        bus.rsp_ready = 4'b1111;
        mul_en = 1'b1;
        #1;
        checkOutput("t6_inflight", 32'(inflight), 0);
        checkOutput("t6_src", 32'(bus.mul_srcReady), 0);
        checkOutput("t6_req_ready", 32'(bus.req_ready), 0);
        checkOutput("t6_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("t6_dest", 32'(bus.mul_destReady), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_first_grant", 32'(bus.req_ready), 1);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 4'b1111);
        waitDrain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
